// File: rtl/mtr_pkg.sv
// Shared motor-interface definitions used by both the PWM driver and decoder.
package mtr_pkg;

  localparam int unsigned SPD_W      = 11;
  localparam int unsigned PWM_PERIOD = 2048;
  localparam int unsigned CNT_W      = 12;

  typedef logic [SPD_W-1:0] spd_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Increment a high-time count when the sampled pin is high, clamped at cnt_max.
  function automatic cnt_t sat_inc(input cnt_t cnt, input logic hit, input cnt_t cnt_max);
    cnt_t res;
    res = cnt;
    if (hit && (cnt < cnt_max)) begin
      res = cnt + CNT_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/mtr_pwm_chan.sv
// One motor channel: synchronizes the forward/reverse pins, measures high time
// per window and resolves speed, direction and conflict at each window close.
module mtr_pwm_chan
  import mtr_pkg::*;
#(
  parameter int unsigned PERIOD      = PWM_PERIOD,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic win_close,
  input  logic pwm_fwd,
  input  logic pwm_rev,
  output spd_t spd,
  output logic rev,
  output logic err
);

  localparam cnt_t CNT_MAX = CNT_W'(PERIOD - 1);

  logic [SYNC_STAGES-1:0] fwd_sync_q, fwd_sync_d;
  logic [SYNC_STAGES-1:0] rev_sync_q, rev_sync_d;
  cnt_t                   fwd_cnt_q, fwd_cnt_d;
  cnt_t                   rev_cnt_q, rev_cnt_d;
  spd_t                   spd_q, spd_d;
  logic                   rev_q, rev_d;
  logic                   err_q, err_d;

  logic                   fwd_s, rev_s;
  cnt_t                   fwd_fin, rev_fin;

  assign fwd_s = fwd_sync_q[SYNC_STAGES-1];
  assign rev_s = rev_sync_q[SYNC_STAGES-1];

  // Synchronizer shift, counting, and close-time output resolution.
  always_comb begin
    fwd_sync_d = {fwd_sync_q[SYNC_STAGES-2:0], pwm_fwd};
    rev_sync_d = {rev_sync_q[SYNC_STAGES-2:0], pwm_rev};

    // Closing counts include the sample taken in the close cycle itself.
    fwd_fin = sat_inc(fwd_cnt_q, fwd_s, CNT_MAX);
    rev_fin = sat_inc(rev_cnt_q, rev_s, CNT_MAX);

    fwd_cnt_d = fwd_fin;
    rev_cnt_d = rev_fin;
    spd_d     = spd_q;
    rev_d     = rev_q;
    err_d     = err_q;

    if (win_close) begin
      fwd_cnt_d = '0;
      rev_cnt_d = '0;
      err_d     = 1'b0;
      if ((fwd_fin != '0) && (rev_fin != '0)) begin
        // Both pins pulsed: flag it and keep the last good reading.
        err_d = 1'b1;
      end else if (rev_fin != '0) begin
        spd_d = SPD_W'(rev_fin);
        rev_d = 1'b1;
      end else begin
        spd_d = SPD_W'(fwd_fin);
        rev_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_sync_q <= '0;
      rev_sync_q <= '0;
      fwd_cnt_q  <= '0;
      rev_cnt_q  <= '0;
      spd_q      <= '0;
      rev_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      fwd_sync_q <= fwd_sync_d;
      rev_sync_q <= rev_sync_d;
      fwd_cnt_q  <= fwd_cnt_d;
      rev_cnt_q  <= rev_cnt_d;
      spd_q      <= spd_d;
      rev_q      <= rev_d;
      err_q      <= err_d;
    end
  end

  assign spd = spd_q;
  assign rev = rev_q;
  assign err = err_q;

endmodule

// File: rtl/mtr_pwm_decode.sv
// Decodes left/right H-bridge PWM pin pairs into signed speed readings over a
// fixed measurement window shared by both channels.
module mtr_pwm_decode
  import mtr_pkg::*;
#(
  parameter int unsigned PERIOD      = PWM_PERIOD,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic PWM_frwrd_lft,
  input  logic PWM_rev_lft,
  input  logic PWM_frwrd_rght,
  input  logic PWM_rev_rght,
  output spd_t lft_spd,
  output logic lft_rev,
  output spd_t rght_spd,
  output logic rght_rev,
  output logic lft_err,
  output logic rght_err,
  output logic spd_vld
);

  spd_t win_cnt_q, win_cnt_d;
  logic spd_vld_q, spd_vld_d;
  logic win_close_c;

  // Window counter and close strobe.
  always_comb begin
    win_close_c = (win_cnt_q == SPD_W'(PERIOD - 1));
    win_cnt_d   = win_close_c ? '0 : (win_cnt_q + SPD_W'(1));
    spd_vld_d   = win_close_c;
  end

  // Window state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt_q <= '0;
      spd_vld_q <= 1'b0;
    end else begin
      win_cnt_q <= win_cnt_d;
      spd_vld_q <= spd_vld_d;
    end
  end

  assign spd_vld = spd_vld_q;

  mtr_pwm_chan #(
    .PERIOD      (PERIOD),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_lft (
    .clk       (clk),
    .rst       (rst),
    .win_close (win_close_c),
    .pwm_fwd   (PWM_frwrd_lft),
    .pwm_rev   (PWM_rev_lft),
    .spd       (lft_spd),
    .rev       (lft_rev),
    .err       (lft_err)
  );

  mtr_pwm_chan #(
    .PERIOD      (PERIOD),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rght (
    .clk       (clk),
    .rst       (rst),
    .win_close (win_close_c),
    .pwm_fwd   (PWM_frwrd_rght),
    .pwm_rev   (PWM_rev_rght),
    .spd       (rght_spd),
    .rev       (rght_rev),
    .err       (rght_err)
  );

endmodule

// File: tb/tb_mtr_pwm_decode.sv
// Directed self-checking bench for mtr_pwm_decode.
module tb_mtr_pwm_decode;
  import mtr_pkg::*;

  localparam int P = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic PWM_frwrd_lft  = 1'b0;
  logic PWM_rev_lft    = 1'b0;
  logic PWM_frwrd_rght = 1'b0;
  logic PWM_rev_rght   = 1'b0;
  spd_t lft_spd, rght_spd;
  logic lft_rev, rght_rev, lft_err, rght_err, spd_vld;

  int errors = 0;
  int checks = 0;
  int tb_cyc = 0;

  int lf_duty = 0, lf_dir = 0, lf_ph = 0;
  int rt_duty = 0, rt_dir = 0, rt_ph = 0;

  mtr_pwm_decode dut (
    .clk            (clk),
    .rst            (rst),
    .PWM_frwrd_lft  (PWM_frwrd_lft),
    .PWM_rev_lft    (PWM_rev_lft),
    .PWM_frwrd_rght (PWM_frwrd_rght),
    .PWM_rev_rght   (PWM_rev_rght),
    .lft_spd        (lft_spd),
    .lft_rev        (lft_rev),
    .rght_spd       (rght_spd),
    .rght_rev       (rght_rev),
    .lft_err        (lft_err),
    .rght_err       (rght_err),
    .spd_vld        (spd_vld)
  );

  always #10 clk = ~clk;

  // Cycle counter that tracks the DUT window position (tb_cyc % P == win_cnt).
  initial forever begin
    @(posedge clk);
    tb_cyc = rst ? 0 : tb_cyc + 1;
  end

  // PWM generator: each pin pattern is a free-running period-P PWM with phase.
  initial forever begin
    @(negedge clk);
    PWM_frwrd_lft  = (((tb_cyc + lf_ph) % P) < lf_duty) && (lf_dir == 0);
    PWM_rev_lft    = (((tb_cyc + lf_ph) % P) < lf_duty) && (lf_dir == 1);
    PWM_frwrd_rght = (((tb_cyc + rt_ph) % P) < rt_duty) && (rt_dir == 0);
    PWM_rev_rght   = (((tb_cyc + rt_ph) % P) < rt_duty) && (rt_dir == 1);
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Count negedges until spd_vld is seen; a missing pulse is a failure.
  task automatic wait_vld(output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 4 * P) begin
      @(negedge clk);
      n++;
      if (spd_vld) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL vld_timeout: no spd_vld within %0d cycles", n);
    end
  endtask

  task automatic wait_pos(input int pos);
    int k;
    k = 0;
    while ((tb_cyc % P) != pos && k < 2 * P) begin
      @(negedge clk);
      k++;
    end
  endtask

  int n;

  initial begin
    lf_duty = 1024;
    lf_ph   = int'($urandom_range(0, P - 1));
    rt_duty = 0;
    repeat (4) @(negedge clk);
    check("rst_lft_spd", int'(lft_spd), 0);
    check("rst_rght_spd", int'(rght_spd), 0);
    check("rst_lft_rev", int'(lft_rev), 0);
    check("rst_lft_err", int'(lft_err), 0);
    check("rst_vld", int'(spd_vld), 0);

    // Steady left forward 1024, right idle; first pulse latency.
    rst = 1'b0;
    wait_vld(n);
    check("first_vld_lat", n, P);
    wait_vld(n);
    check("fwd1024_spd", int'(lft_spd), 1024);
    check("fwd1024_rev", int'(lft_rev), 0);
    check("idle_rght_spd", int'(rght_spd), 0);
    check("fwd1024_err", int'(lft_err), 0);
    check("idle_rght_err", int'(rght_err), 0);

    // Left duty 0; right reverse 300.
    lf_duty = 0;
    rt_dir  = 1;
    rt_duty = 300;
    rt_ph   = int'($urandom_range(0, P - 1));
    wait_vld(n);
    wait_vld(n);
    check("duty0_spd", int'(lft_spd), 0);
    check("duty0_rev", int'(lft_rev), 0);
    check("rev300_spd", int'(rght_spd), 300);
    check("rev300_rev", int'(rght_rev), 1);
    check("rev300_err", int'(rght_err), 0);

    // Left duty 2047.
    lf_duty = 2047;
    wait_vld(n);
    wait_vld(n);
    check("duty2047_spd", int'(lft_spd), 2047);
    check("duty2047_err", int'(lft_err), 0);

    // Constant-high pin saturates.
    lf_duty = P;
    wait_vld(n);
    wait_vld(n);
    check("const_hi_spd", int'(lft_spd), 2047);
    check("const_hi_rev", int'(lft_rev), 0);
    check("const_hi_err", int'(lft_err), 0);

    // Forward 500 with pulse centred mid-window, then flip direction mid-pulse.
    lf_duty = 500;
    lf_ph   = 1298;
    wait_vld(n);
    wait_vld(n);
    check("fwd500_spd", int'(lft_spd), 500);
    check("fwd500_rev", int'(lft_rev), 0);
    wait_pos(1000);
    lf_dir = 1;
    wait_vld(n);
    check("flip_err", int'(lft_err), 1);
    check("flip_hold_spd", int'(lft_spd), 500);
    check("flip_hold_rev", int'(lft_rev), 0);
    check("flip_rght_err", int'(rght_err), 0);
    wait_vld(n);
    check("rev500_err", int'(lft_err), 0);
    check("rev500_rev", int'(lft_rev), 1);
    check("rev500_spd", int'(lft_spd), 500);

    // Mid-window reset.
    wait_pos(1000);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_lft_spd", int'(lft_spd), 0);
    check("mrst_lft_rev", int'(lft_rev), 0);
    check("mrst_rght_spd", int'(rght_spd), 0);
    check("mrst_rght_rev", int'(rght_rev), 0);
    check("mrst_vld", int'(spd_vld), 0);
    rst = 1'b0;
    wait_vld(n);
    check("mrst_vld_lat", n, P);

    // spd_vld cadence and width over 10 windows.
    for (int w = 0; w < 10; w++) begin
      @(negedge clk);
      check("vld_width", int'(spd_vld), 0);
      wait_vld(n);
      check("vld_period", n + 1, P);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mtr_pwm_decode.md
# mtr_pwm_decode

Recovers the signed motor command from the H-bridge PWM pins and is the receive-side counterpart of the motor driver. It samples the forward/reverse PWM pair for the left and right motors, measures high time over a fixed 2048-cycle window and reports an 11-bit speed plus a reverse flag per motor. It sits on the bench/monitor side of the motor interface, for closed-loop self-check and for verification of the drive path. Either PWM pin of a pair may carry pulses, but never both in the same window.

## Interface
- PERIOD, 2048, measurement window length in clk cycles; equals the driver PWM period.
- SYNC_STAGES, 2, flops in each input synchronizer; minimum 2.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, synchronous, active-high.
- PWM_frwrd_lft  in  1  left forward PWM pin; asynchronous to clk.
- PWM_rev_lft  in  1  left reverse PWM pin; asynchronous to clk.
- PWM_frwrd_rght  in  1  right forward PWM pin; asynchronous to clk.
- PWM_rev_rght  in  1  right reverse PWM pin; asynchronous to clk.
- lft_spd  out  11  decoded left duty, 0..2047.
- lft_rev  out  1  left decoded as reverse.
- rght_spd  out  11  decoded right duty, 0..2047.
- rght_rev  out  1  right decoded as reverse.
- lft_err  out  1  both left pins pulsed in the last window.
- rght_err  out  1  both right pins pulsed in the last window.
- spd_vld  out  1  one-cycle pulse when all outputs update.

## Operation
- Every PWM input passes through a SYNC_STAGES flop synchronizer before any use.
- Window counter win_cnt (11 bits) runs 0..PERIOD-1 and then wraps to 0. It is shared by both channels.
- Each channel keeps a forward high-count and a reverse high-count (12 bits each). Each count increments on every cycle its synchronized pin is 1, and saturates at PERIOD-1.
- Any PERIOD consecutive cycles of a steady PWM contain exactly duty high cycles, so window-to-PWM phase alignment is irrelevant.
- At window close (win_cnt == PERIOD-1, including that cycle's sample), the closed counts update the channel outputs as follows:
  - fwd > 0 and rev == 0: spd = fwd, rev flag = 0, err = 0.
  - rev > 0 and fwd == 0: spd = rev, rev flag = 1, err = 0.
  - both == 0: spd = 0, rev flag = 0, err = 0.
  - both > 0: err = 1; spd and rev flag hold their previous values.
- Both counts restart for the new window, starting with the sample taken at win_cnt == 0.
- err is per-window, not sticky; it is recomputed at every close.

## Timing
- Reset values: all outputs 0, win_cnt 0, counts 0, synchronizer flops 0.
- Pin-to-counted latency: SYNC_STAGES cycles.
- Outputs and spd_vld change on the clock edge after the close cycle. spd_vld is high for exactly 1 cycle every PERIOD cycles.
- The first spd_vld occurs PERIOD cycles after rst deasserts.
- A duty change takes effect in the window after it settles. The transition window may report an intermediate value; no err is raised unless the direction also changed.
- rst asserted mid-window discards the partial window and returns all state to reset values on the next edge.
- A pin held constantly high reports 2047 (saturated).

## Structure
- Package mtr_pkg: SPD_W = 11, PWM_PERIOD = 2048, typedef logic [SPD_W-1:0] spd_t. Shared with the motor driver.
- Sub-module mtr_pwm_chan holds the synchronizers, the two high-counters and the output/err logic for one motor. It is instantiated twice (left, right).
- Top level holds win_cnt, generates the window-close strobe and spd_vld, and instantiates the two channels.

## Test plan
- Left forward duty 1024 with random phase offset, right idle -> after the second spd_vld: lft_spd = 1024, lft_rev = 0, rght_spd = 0, no err.
- Right reverse duty 300 -> rght_spd = 300, rght_rev = 1, PWM_frwrd_rght silent, rght_err = 0.
- Duty 0 and duty 2047 forward -> spd reads 0 and 2047 respectively; the constant-high pin saturates at 2047, with no overflow.
- Left direction flip from forward 500 to reverse 500 mid-window -> that window: lft_err = 1, lft_spd = 500, lft_rev = 0 held; next window: lft_rev = 1, lft_err = 0.
- rst pulsed at win_cnt = 1000 -> all outputs 0 on the next edge; next spd_vld exactly 2048 cycles after rst deasserts.
- spd_vld monitor over 10 windows -> exactly one single-cycle pulse every 2048 cycles.
